// File: rtl/coax_pkg.sv
// Shared definitions for the coax receiver reader: word width and reader FSM states.
package coax_pkg;

    localparam int unsigned WORD_WIDTH  = 10;
    localparam int unsigned ENTRY_WIDTH = WORD_WIDTH + 1;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StRecover
    } reader_state_e;

endpackage

// File: rtl/coax_sync_fifo.sv
// Single-clock FIFO with occupancy count; a push while full is accepted only alongside a pop.
module coax_sync_fifo #(
    parameter int unsigned WIDTH = 11,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q, level_d;
    logic             push_ok, pop_ok;

    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign pop_ok  = pop && !empty;
    // When full, the slot being vacated by the pop is reused by the push.
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        level_d = level_q;
        if (push_ok && !pop_ok) begin
            level_d = level_q + LVL_W'(1);
        end else if (!push_ok && pop_ok) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            level_q <= level_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign level = level_q;

endmodule

// File: rtl/coax_rx_reader.sv
// Drains words from the coax receiver with a timed read strobe and queues them for a consumer.
module coax_rx_reader
    import coax_pkg::*;
#(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned READ_CLOCKS = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    data_available,
    input  logic                    rx_active,
    input  logic [WORD_WIDTH-1:0]   data_in,
    output logic                    register_read_n,
    output logic                    output_enable,
    output logic [ENTRY_WIDTH-1:0]  rx_data,
    output logic                    rx_valid,
    input  logic                    rx_ready,
    output logic                    overflow,
    input  logic                    overflow_clear,
    output logic [$clog2(DEPTH):0]  level
);

    localparam logic [3:0] LAST_CNT = 4'(READ_CLOCKS - 1);

    reader_state_e            state_q, state_d;
    logic [3:0]               cnt_q, cnt_d;
    logic [ENTRY_WIDTH-1:0]   word_q;
    logic                     overflow_q, overflow_d;
    logic                     push, pop, drop;
    logic                     fifo_full, fifo_empty;
    logic                     read_last;

    assign read_last = (state_q == StRead) && (cnt_q == LAST_CNT);

    // Strobes are decoded from the registered state so reset releases them without a clock.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        register_read_n = 1'b1;
        output_enable   = 1'b0;
        push            = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (data_available) begin
                    state_d = StRead;
                end
            end
            StRead: begin
                register_read_n = 1'b0;
                output_enable   = 1'b1;
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    state_d = StRecover;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StRecover: begin
                push    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_q <= '0;
        end else if (read_last) begin
            word_q <= {~rx_active, data_in};
        end
    end

    assign rx_valid = !fifo_empty;
    assign pop      = rx_valid && rx_ready;
    assign drop     = push && fifo_full && !pop;

    // A new drop outranks a clear arriving in the same cycle.
    always_comb begin
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (overflow_clear) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;

    coax_sync_fifo #(
        .WIDTH (ENTRY_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .wdata   (word_q),
        .pop     (pop),
        .rdata   (rx_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

endmodule

// File: tb/tb_coax_rx_reader.sv
// Directed bench for coax_rx_reader: behavioural receiver feeding words, consumer driven per test.
module tb_coax_rx_reader;

    localparam int unsigned DEPTH       = 16;
    localparam int unsigned READ_CLOCKS = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        data_available;
    logic        rx_active;
    logic [9:0]  data_in;
    logic        register_read_n;
    logic        output_enable;
    logic [10:0] rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        overflow;
    logic        overflow_clear;
    logic [4:0]  level;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int pulses = 0;

    // Receiver model: words queued by the tests, consumed on each read strobe release.
    logic [10:0] src_mem [64];
    logic [7:0]  src_wr = 8'd0;
    logic [7:0]  src_rd = 8'd0;

    assign data_available = (src_rd != src_wr);
    assign data_in        = src_mem[src_rd[5:0]][9:0];
    assign rx_active      = src_mem[src_rd[5:0]][10];

    // Consumer-side collector for the streaming test.
    logic        col_en = 1'b0;
    logic [10:0] got [16];
    int          got_cyc [16];
    int          got_n = 0;
    int          max_lvl = 0;

    coax_rx_reader #(
        .DEPTH       (DEPTH),
        .READ_CLOCKS (READ_CLOCKS)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .data_available  (data_available),
        .rx_active       (rx_active),
        .data_in         (data_in),
        .register_read_n (register_read_n),
        .output_enable   (output_enable),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid),
        .rx_ready        (rx_ready),
        .overflow        (overflow),
        .overflow_clear  (overflow_clear),
        .level           (level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge register_read_n) pulses++;

    always @(posedge register_read_n) begin
        #1;
        if (src_rd != src_wr) src_rd = src_rd + 8'd1;
    end

    always @(negedge clk) begin
        if (col_en) begin
            if (int'(level) > max_lvl) max_lvl = int'(level);
            if (rx_valid && rx_ready && got_n < 16) begin
                got[got_n]     = rx_data;
                got_cyc[got_n] = cyc;
                got_n++;
            end
        end
    end

    task automatic enqueue(input logic [9:0] w, input logic act);
        src_mem[src_wr[5:0]] = {act, w};
        src_wr = src_wr + 8'd1;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (src_rd == src_wr) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic wait_read_low(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!register_read_n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n        = 1'b0;
        rx_ready       = 1'b0;
        overflow_clear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (register_read_n !== 1'b1) begin fails++;
            $display("FAIL reset_rrn: got %b expected 1", register_read_n); end
        tests++; if (output_enable !== 1'b0) begin fails++;
            $display("FAIL reset_oe: got %b expected 0", output_enable); end
        tests++; if (rx_valid !== 1'b0) begin fails++;
            $display("FAIL reset_valid: got %b expected 0", rx_valid); end
        tests++; if (overflow !== 1'b0) begin fails++;
            $display("FAIL reset_overflow: got %b expected 0", overflow); end
        tests++; if (level !== 5'd0) begin fails++;
            $display("FAIL reset_level: got %0d expected 0", level); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_single_word();
        int r0, low, oe_low, v;
        @(posedge clk); #1;
        enqueue(10'h2A5, 1'b0);
        r0 = -1; low = 0; oe_low = 0; v = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!register_read_n) begin
                low++;
                if (r0 < 0) r0 = i;
                if (output_enable) oe_low++;
            end
            if (rx_valid && v < 0) v = i;
        end
        tests++; if (low != 2) begin fails++;
            $display("FAIL single_rrn_cycles: got %0d expected 2", low); end
        tests++; if (oe_low != 2) begin fails++;
            $display("FAIL single_oe_cycles: got %0d expected 2", oe_low); end
        tests++; if (r0 != 1) begin fails++;
            $display("FAIL single_read_start: got %0d expected 1", r0); end
        tests++; if (v != 4) begin fails++;
            $display("FAIL single_valid_cycle: got %0d expected 4", v); end
        tests++; if (rx_data !== 11'h6A5) begin fails++;
            $display("FAIL single_data: got %h expected 6a5", rx_data); end
        tests++; if (level !== 5'd1) begin fails++;
            $display("FAIL single_level: got %0d expected 1", level); end
        @(posedge clk); #1;
        rx_ready = 1'b1;
        @(posedge clk); #1;
        rx_ready = 1'b0;
        tests++; if (level !== 5'd0 || rx_valid !== 1'b0) begin fails++;
            $display("FAIL single_pop: got level %0d valid %b expected 0 0", level, rx_valid); end
    endtask

    task automatic test_back_to_back();
        int  base, n;
        bit  ok;
        logic [10:0] exp;
        @(posedge clk); #1;
        base     = got_n;
        col_en   = 1'b1;
        rx_ready = 1'b1;
        for (int i = 0; i < 5; i++) enqueue(10'(i + 1), (i == 4) ? 1'b0 : 1'b1);
        wait_idle(100, ok);
        col_en   = 1'b0;
        rx_ready = 1'b0;
        n = got_n - base;
        tests++; if (!ok) begin fails++;
            $display("FAIL b2b_timeout: got busy expected drained"); end
        tests++; if (n != 5) begin fails++;
            $display("FAIL b2b_count: got %0d expected 5", n); end
        for (int i = 0; i < n && i < 5; i++) begin
            exp = {(i == 4), 10'(i + 1)};
            tests++; if (got[base + i] !== exp) begin fails++;
                $display("FAIL b2b_word%0d: got %h expected %h", i, got[base + i], exp); end
            if (i > 0) begin
                tests++; if (got_cyc[base + i] - got_cyc[base + i - 1] != 4) begin fails++;
                    $display("FAIL b2b_spacing%0d: got %0d expected 4", i,
                             got_cyc[base + i] - got_cyc[base + i - 1]); end
            end
        end
        tests++; if (max_lvl > 1) begin fails++;
            $display("FAIL b2b_max_level: got %0d expected <=1", max_lvl); end
    endtask

    task automatic test_overflow();
        int p0;
        bit ok;
        @(posedge clk); #1;
        p0 = pulses;
        for (int i = 0; i < 17; i++) enqueue(10'(32'h100 + i), 1'b1);
        wait_idle(200, ok);
        tests++; if (!ok) begin fails++;
            $display("FAIL ovf_timeout: got busy expected drained"); end
        tests++; if (level !== 5'd16) begin fails++;
            $display("FAIL ovf_level: got %0d expected 16", level); end
        tests++; if (overflow !== 1'b1) begin fails++;
            $display("FAIL ovf_flag: got %b expected 1", overflow); end
        tests++; if (pulses - p0 != 17) begin fails++;
            $display("FAIL ovf_pulses: got %0d expected 17", pulses - p0); end
        tests++; if (rx_valid !== 1'b1 || rx_data !== 11'h100) begin fails++;
            $display("FAIL ovf_head: got %b %h expected 1 100", rx_valid, rx_data); end
    endtask

    task automatic test_full_push_pop();
        bit ok;
        logic [10:0] exp;
        @(posedge clk); #1;
        overflow_clear = 1'b1;
        @(posedge clk); #1;
        overflow_clear = 1'b0;
        tests++; if (overflow !== 1'b0) begin fails++;
            $display("FAIL fpp_clear: got %b expected 0", overflow); end
        enqueue(10'h3CC, 1'b0);
        wait_read_low(ok);
        tests++; if (!ok) begin fails++;
            $display("FAIL fpp_no_read: got no strobe expected strobe"); end
        @(posedge clk);
        @(posedge clk); #1;
        rx_ready = 1'b1;
        @(posedge clk); #1;
        rx_ready = 1'b0;
        tests++; if (level !== 5'd16) begin fails++;
            $display("FAIL fpp_level: got %0d expected 16", level); end
        tests++; if (overflow !== 1'b0) begin fails++;
            $display("FAIL fpp_overflow: got %b expected 0", overflow); end
        rx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            exp = (i < 15) ? 11'(32'h101 + i) : 11'h7CC;
            tests++; if (rx_data !== exp) begin fails++;
                $display("FAIL fpp_drain%0d: got %h expected %h", i, rx_data, exp); end
        end
        @(posedge clk); #1;
        rx_ready = 1'b0;
        tests++; if (level !== 5'd0 || rx_valid !== 1'b0) begin fails++;
            $display("FAIL fpp_empty: got level %0d valid %b expected 0 0", level, rx_valid); end
    endtask

    task automatic test_reset_mid_read();
        bit ok;
        int lows;
        @(posedge clk); #1;
        enqueue(10'h0F0, 1'b1);
        wait_read_low(ok);
        tests++; if (!ok) begin fails++;
            $display("FAIL rmr_no_read: got no strobe expected strobe"); end
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        tests++; if (register_read_n !== 1'b1) begin fails++;
            $display("FAIL rmr_rrn_async: got %b expected 1", register_read_n); end
        tests++; if (output_enable !== 1'b0) begin fails++;
            $display("FAIL rmr_oe_async: got %b expected 0", output_enable); end
        @(negedge clk);
        reset_n = 1'b1;
        lows = 0;
        repeat (3) begin
            @(negedge clk);
            if (!register_read_n) lows++;
        end
        tests++; if (lows != 0) begin fails++;
            $display("FAIL rmr_idle: got %0d strobe cycles expected 0", lows); end
        tests++; if (level !== 5'd0 || rx_valid !== 1'b0) begin fails++;
            $display("FAIL rmr_level: got level %0d valid %b expected 0 0", level, rx_valid); end
        @(posedge clk); #1;
        enqueue(10'h155, 1'b0);
        wait_idle(20, ok);
        tests++; if (rx_data !== 11'h555 || level !== 5'd1) begin fails++;
            $display("FAIL rmr_fresh: got %h level %0d expected 555 level 1", rx_data, level); end
        rx_ready = 1'b1;
        @(posedge clk); #1;
        rx_ready = 1'b0;
    endtask

    task automatic test_overflow_clear();
        bit ok;
        @(posedge clk); #1;
        for (int i = 0; i < 17; i++) enqueue(10'(32'h200 + i), 1'b1);
        wait_idle(200, ok);
        tests++; if (!ok || overflow !== 1'b1 || level !== 5'd16) begin fails++;
            $display("FAIL ovc_setup: got ok %b ovf %b level %0d expected 1 1 16",
                     ok, overflow, level); end
        enqueue(10'h3FF, 1'b1);
        wait_read_low(ok);
        tests++; if (!ok) begin fails++;
            $display("FAIL ovc_no_read: got no strobe expected strobe"); end
        @(posedge clk);
        @(posedge clk); #1;
        overflow_clear = 1'b1;
        @(posedge clk); #1;
        tests++; if (overflow !== 1'b1) begin fails++;
            $display("FAIL ovc_set_wins: got %b expected 1", overflow); end
        tests++; if (level !== 5'd16) begin fails++;
            $display("FAIL ovc_level: got %0d expected 16", level); end
        @(posedge clk); #1;
        overflow_clear = 1'b0;
        tests++; if (overflow !== 1'b0) begin fails++;
            $display("FAIL ovc_clear: got %b expected 0", overflow); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_overflow();
        test_full_push_pop();
        test_reset_mid_read();
        test_overflow_clear();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/coax_rx_reader.md
COAX_RX_READER -- requirements
Module: coax_rx_reader

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning FIFO word capacity (power of two, 4..256).
REQ-002 SHALL have parameter READ_CLOCKS, default 2, meaning cycles register_read_n is held low per word (1..15).
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port data_available  input  1  receiver holds an unread word (synchronous to clk).
REQ-006 SHALL have port rx_active  input  1  receiver is inside a message (synchronous to clk).
REQ-007 SHALL have port data_in  input  10  receiver word bus.
REQ-008 SHALL have port register_read_n  output  1  active-low read strobe to receiver.
REQ-009 SHALL have port output_enable  output  1  drives receiver word onto data_in.
REQ-010 SHALL have port rx_data  output  11  {last, word[9:0]} at FIFO head.
REQ-011 SHALL have port rx_valid  output  1  FIFO non-empty.
REQ-012 SHALL have port rx_ready  input  1  consumer pop; pop occurs when rx_valid and rx_ready are both high.
REQ-013 SHALL have port overflow  output  1  sticky: word dropped because FIFO full.
REQ-014 SHALL have port overflow_clear  input  1  clears overflow.
REQ-015 SHALL have port level  output  $clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-016 SHALL implement an FSM with states IDLE, READ, RECOVER.
REQ-017 IDLE: register_read_n=1, output_enable=0; SHALL enter READ on the cycle after data_available is sampled high.
REQ-018 READ: output_enable=1 for all cycles; register_read_n=0 for exactly READ_CLOCKS cycles; SHALL go to RECOVER after the last one.
REQ-019 SHALL capture data_in and rx_active on the last READ cycle; last = ~rx_active sampled on that cycle.
REQ-020 RECOVER: register_read_n=1, output_enable=0 for exactly 1 cycle; then return to IDLE; back-to-back words therefore take READ_CLOCKS+2 cycles each.
REQ-021 SHALL push the captured word into the FIFO on the RECOVER cycle.
REQ-022 SHALL always perform the READ cycle when data_available is high, even if the FIFO is full, so the receiver is drained.
REQ-023 FIFO full at push with no simultaneous pop: SHALL discard the word, set overflow, and leave level unchanged.
REQ-024 FIFO full at push with a simultaneous pop: SHALL accept the word, leave level unchanged, and not set overflow.
REQ-025 FIFO empty: SHALL ignore rx_ready; rx_data SHALL be don't-care; no underflow.
REQ-026 Push into an empty FIFO: SHALL raise rx_valid the following cycle (1-cycle write-to-read latency); rx_data SHALL be registered FIFO head.
REQ-027 Read and write pointers SHALL wrap modulo DEPTH; level SHALL range 0..DEPTH.
REQ-028 overflow_clear and a new overflow in the same cycle: SHALL leave overflow set (set wins).
REQ-029 data_available dropping during READ SHALL NOT abort the sequence; the word is still captured.

Reset
REQ-030 While reset_n=0: register_read_n=1, output_enable=0, rx_valid=0, overflow=0, level=0, FSM=IDLE, pointers=0.
REQ-031 Reset asserted mid-READ SHALL immediately (asynchronously) release register_read_n and output_enable; the partial word SHALL be lost.
REQ-032 After reset_n rises, SHALL sample data_available no earlier than the first clk edge.

Structure
REQ-033 Shared package coax_pkg SHALL hold WORD_WIDTH=10 and the reader state enum.
REQ-034 FIFO storage and pointers SHALL be one sub-module, coax_sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/level); the FSM stays in coax_rx_reader.

Verification
REQ-035 Single word 0x2A5 with rx_active=0 at sample -> register_read_n low 2 cycles, rx_data=0x6A5 (last=1), rx_valid 1 cycle after RECOVER, level=1.
REQ-036 data_available held high for 5 words 0x001..0x005, rx_ready=1 -> 5 words in order, one per 4 cycles, level never exceeds 1.
REQ-037 rx_ready=0, 17 words with DEPTH=16 -> level=16, 17th word dropped, overflow=1, register_read_n still pulsed 17 times.
REQ-038 FIFO full, push and pop in the same cycle -> level stays 16, overflow stays 0, new word appears at tail.
REQ-039 reset_n low during the 2nd READ cycle -> register_read_n=1 and output_enable=0 without waiting for a clk edge; after release level=0 and the FSM is in IDLE.
REQ-040 overflow set, then overflow_clear and an overflowing push in the same cycle -> overflow remains 1; overflow_clear alone on the next cycle -> 0.
